// File: rtl/add_round_key_reg_pkg.sv
// rtl/add_round_key_reg_pkg.sv - shared constants and FSM encoding for the add-round-key stage
package add_round_key_reg_pkg;

    localparam int SIZE_STATE_DEF = 64;
    localparam int NUM_ROUNDS_DEF = 8;
    localparam int ROUND_W_DEF    = $clog2(NUM_ROUNDS_DEF);

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/add_round_key_reg_if.sv
// rtl/add_round_key_reg_if.sv - input/output handshake bundle of the add-round-key stage
interface add_round_key_reg_if
    import add_round_key_reg_pkg::*;
#(
    parameter int SIZE_STATE = SIZE_STATE_DEF,
    parameter int ROUND_W    = ROUND_W_DEF
) ();

    logic [SIZE_STATE-1:0] in_state;
    logic                  in_valid;
    logic                  in_ready;
    logic [SIZE_STATE-1:0] round_key;
    logic [ROUND_W-1:0]    round_idx;
    logic [SIZE_STATE-1:0] out_state;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    // Upstream permutation plus downstream consumer side
    modport master (
        output in_state, in_valid, round_key, out_ready,
        input  in_ready, round_idx, out_state, out_valid, out_last
    );

    // The add-round-key stage itself
    modport slave (
        input  in_state, in_valid, round_key, out_ready,
        output in_ready, round_idx, out_state, out_valid, out_last
    );

endinterface

// File: rtl/add_round_key_reg_round_ctr.sv
// rtl/add_round_key_reg_round_ctr.sv - round index counter that saturates on the final round
module add_round_key_reg_round_ctr #(
    parameter int NUM_ROUNDS = 8,
    parameter int ROUND_W    = $clog2(NUM_ROUNDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    output logic [ROUND_W-1:0] idx,
    output logic               is_last
);

    localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

    logic [ROUND_W-1:0] idx_q;
    logic [ROUND_W-1:0] idx_d;

    assign is_last = (idx_q == LAST_IDX);
    assign idx     = idx_q;

    // Clear wins over increment; the index holds once it reaches the last round
    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (inc && !is_last) begin
            idx_d = idx_q + ROUND_W'(1);
        end
    end

    // Round index register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/add_round_key_reg.sv
// rtl/add_round_key_reg.sv - XORs round key and round constant into the permuted state and registers it
module add_round_key_reg
    import add_round_key_reg_pkg::*;
#(
    parameter int SIZE_STATE = SIZE_STATE_DEF,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    add_round_key_reg_if.slave     bus
);

    localparam int ROUND_W = $clog2(NUM_ROUNDS);

    fsm_state_t            state_q;
    fsm_state_t            state_d;
    logic [SIZE_STATE-1:0] out_state_q;
    logic [SIZE_STATE-1:0] out_state_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  out_last_q;
    logic                  out_last_d;

    logic                  accept;
    logic                  consume;
    logic                  in_ready;
    logic [ROUND_W-1:0]    idx;
    logic                  is_last;

    // The round constant lives in the low ROUND_W bits only
    function automatic logic [SIZE_STATE-1:0] round_const(input logic [ROUND_W-1:0] r);
        return {{(SIZE_STATE - ROUND_W){1'b0}}, r};
    endfunction

    add_round_key_reg_round_ctr #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .ROUND_W    (ROUND_W)
    ) u_round_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .inc     (accept),
        .idx     (idx),
        .is_last (is_last)
    );

    // A single output register: accept only when it is empty or being drained this cycle.
    // A start pulse aborts the block, so nothing is accepted in that cycle.
    assign in_ready = (state_q == ST_RUN) && !start && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = out_valid_q && bus.out_ready;

    // Next-state logic for the FSM and the output register
    always_comb begin
        state_d     = state_q;
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (start) begin
            state_d     = ST_RUN;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (accept) begin
            out_state_d = bus.in_state ^ bus.round_key ^ round_const(idx);
            out_valid_d = 1'b1;
            out_last_d  = is_last;
            if (is_last) begin
                state_d = ST_DRAIN;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (state_q == ST_DRAIN) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.round_idx = idx;
    assign bus.out_state = out_state_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule
